// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: FSM state encoding,
// read/write flag values and default field widths.
package bus_pkg;

  localparam int ADDR_LEN_DEF = 12;
  localparam int DATA_LEN_DEF = 8;

  // m_rw flag values; they track bit 0 of the bus instruction codes
  // (write 2'b10, read 2'b11) inverted.
  localparam logic       RW_WRITE    = 1'b1;
  localparam logic       RW_READ     = 1'b0;
  localparam logic [1:0] INSTR_WRITE = 2'b10;
  localparam logic [1:0] INSTR_READ  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX_ADDR   = 3'd1,
    ST_RX_DATA   = 3'd2,
    ST_MEM_WRITE = 3'd3,
    ST_MEM_READ  = 3'd4,
    ST_TX_DATA   = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  // Map a bus instruction code to the m_rw flag value.
  function automatic logic rw_from_instr(input logic [1:0] instr);
    return ~instr[0];
  endfunction

  // Largest of three sizes; used to dimension the shared bit counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// MSB-first shift register: serial in at the LSB, MSB is the serial out,
// with a parallel load that takes priority over shifting.
module serial_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_shift_en,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Shift register contents: load, shift left, or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift_en) begin
      r_q <= {r_q[WIDTH-2:0], i_sin};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bus_slave_port.sv
// Responder end of the serial system bus: shifts in a 12-bit address and
// optional 8-bit write data, performs one byte access on a block RAM and
// serialises read data back to the master.
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_LEN     = ADDR_LEN_DEF,
  parameter int DATA_LEN     = DATA_LEN_DEF,
  parameter int MEM_DEPTH    = 4096,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m_valid,
  input  logic                m_rw,
  input  logic                m_data,
  output logic                s_ready,
  output logic                s_valid,
  output logic                s_data,
  output logic                s_done,
  output logic                s_err,
  output logic                busy,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_we,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  localparam int CNT_MAX = max3(ADDR_LEN, DATA_LEN, READ_LATENCY + 1);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // The first address bit arrives in IDLE, so RX_ADDR sees ADDR_LEN-1 bits.
  localparam logic [CNT_W-1:0] ADDR_LAST_C = CNT_W'(ADDR_LEN - 2);
  localparam logic [CNT_W-1:0] DATA_LAST_C = CNT_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0] READ_LAST_C = CNT_W'(READ_LATENCY);
  localparam logic [ADDR_LEN:0] DEPTH_C    = (ADDR_LEN + 1)'(MEM_DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rw;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_addr_shift;
  logic                w_data_shift;
  logic                w_data_load;
  logic                w_data_sin;
  logic [ADDR_LEN-1:0] w_addr_q;
  logic [DATA_LEN-1:0] w_data_q;
  logic [ADDR_LEN-1:0] w_addr_full;
  logic [DATA_LEN-1:0] w_data_full;
  logic [DATA_LEN-1:0] w_data_load_val;
  logic                w_oor;

  logic                r_s_ready;
  logic                r_s_valid;
  logic                r_s_done;
  logic                r_s_err;
  logic                r_busy;
  logic [ADDR_LEN-1:0] r_mem_addr;
  logic [DATA_LEN-1:0] r_mem_wdata;
  logic                r_mem_we;

  // Values including the bit being shifted in on this cycle's edge.
  assign w_addr_full     = {w_addr_q[ADDR_LEN-2:0], m_data};
  assign w_data_full     = {w_data_q[DATA_LEN-2:0], m_data};
  assign w_oor           = ({1'b0, w_addr_q} >= DEPTH_C);
  assign w_data_load_val = w_oor ? '0 : mem_rdata;

  serial_shifter #(.WIDTH(ADDR_LEN)) u_addr_shift (
    .clk        (clk),
    .reset      (reset),
    .i_load     (1'b0),
    .i_load_val ({ADDR_LEN{1'b0}}),
    .i_shift_en (w_addr_shift),
    .i_sin      (m_data),
    .o_q        (w_addr_q)
  );

  // Same register captures write data and then transmits read data.
  serial_shifter #(.WIDTH(DATA_LEN)) u_data_shift (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_data_load),
    .i_load_val (w_data_load_val),
    .i_shift_en (w_data_shift),
    .i_sin      (w_data_sin),
    .o_q        (w_data_q)
  );

  // State register and the direction flag latched on the start cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rw    <= RW_READ;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && m_valid) begin
        r_rw <= m_rw;
      end else begin
        r_rw <= r_rw;
      end
    end
  end

  // Next-state logic and shifter controls.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_shift = 1'b0;
    w_data_shift = 1'b0;
    w_data_load  = 1'b0;
    w_data_sin   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m_valid) begin
          w_addr_shift = 1'b1;
          w_state_nxt  = ST_RX_ADDR;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_RX_ADDR: begin
        if (!m_valid) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_addr_shift = 1'b1;
          if (r_cnt == ADDR_LAST_C) begin
            w_state_nxt = (r_rw == RW_WRITE) ? ST_RX_DATA : ST_MEM_READ;
          end else begin
            w_state_nxt = ST_RX_ADDR;
          end
        end
      end
      ST_RX_DATA: begin
        w_data_sin = m_data;
        if (!m_valid) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_data_shift = 1'b1;
          if (r_cnt == DATA_LAST_C) begin
            w_state_nxt = ST_MEM_WRITE;
          end else begin
            w_state_nxt = ST_RX_DATA;
          end
        end
      end
      ST_MEM_WRITE: begin
        w_state_nxt = ST_DONE;
      end
      ST_MEM_READ: begin
        if (r_cnt == READ_LAST_C) begin
          w_data_load = 1'b1;
          w_state_nxt = ST_TX_DATA;
        end else begin
          w_state_nxt = ST_MEM_READ;
        end
      end
      ST_TX_DATA: begin
        w_data_shift = 1'b1;
        if (r_cnt == DATA_LAST_C) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_TX_DATA;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Per-state bit counter: cleared on every state entry and held at zero in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state || r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_ready   <= 1'b0;
      r_s_valid   <= 1'b0;
      r_s_done    <= 1'b0;
      r_s_err     <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_s_ready <= (w_state_nxt == ST_IDLE);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_s_valid <= (w_state_nxt == ST_TX_DATA);
      r_s_done  <= (w_state_nxt == ST_DONE);
      r_s_err   <= (w_state_nxt == ST_DONE) && w_oor;
      r_mem_we  <= (w_state_nxt == ST_MEM_WRITE) && !w_oor;
      if (r_state == ST_RX_DATA && w_state_nxt == ST_MEM_WRITE) begin
        r_mem_addr  <= w_addr_q;
        r_mem_wdata <= w_data_full;
      end else if (r_state == ST_RX_ADDR && w_state_nxt == ST_MEM_READ) begin
        r_mem_addr  <= w_addr_full;
        r_mem_wdata <= r_mem_wdata;
      end else begin
        r_mem_addr  <= r_mem_addr;
        r_mem_wdata <= r_mem_wdata;
      end
    end
  end

  assign s_ready   = r_s_ready;
  assign s_valid   = r_s_valid;
  // Serial data is the shifter MSB, forced low outside the transmit window.
  assign s_data    = r_s_valid & w_data_q[DATA_LEN-1];
  assign s_done    = r_s_done;
  assign s_err     = r_s_err;
  assign busy      = r_busy;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_bus_slave_port.sv
// Scoreboard bench for bus_slave_port. Instance 0 uses default parameters;
// instance 1 uses MEM_DEPTH=2048 and READ_LATENCY=3.
module tb_bus_slave_port;

  typedef struct {
    int         done_t;
    int         we_cnt;
    int         we_t;
    logic [11:0] we_addr;
    logic [7:0]  we_data;
    int         tx_cnt;
    int         tx_t;
    logic [7:0]  tx_byte;
    int         err;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst     [2];
  logic        m_valid [2];
  logic        m_rw    [2];
  logic        m_data  [2];
  logic        s_ready [2];
  logic        s_valid [2];
  logic        s_data  [2];
  logic        s_done  [2];
  logic        s_err   [2];
  logic        busy    [2];
  logic [11:0] mem_addr  [2];
  logic [7:0]  mem_wdata [2];
  logic        mem_we    [2];
  logic [7:0]  mem_rdata [2];

  logic [7:0] ram_a [4096];
  logic [7:0] ram_b [4096];
  logic [7:0] pipe_b1, pipe_b2;

  rec_t exp_q0[$];
  rec_t exp_q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Monitor collection state per instance.
  int         t0 [2];
  int         busy_cnt [2];
  int         we_cnt [2];
  int         we_t [2];
  logic [11:0] we_addr [2];
  logic [7:0]  we_data [2];
  int         tx_cnt [2];
  int         tx_t [2];
  logic [7:0]  tx_byte [2];
  int         stray [2];
  logic       rst_pend [2];
  logic       ready_pend [2];

  always #5 clk = ~clk;

  bus_slave_port dut_a (
    .clk(clk), .reset(rst[0]), .m_valid(m_valid[0]), .m_rw(m_rw[0]), .m_data(m_data[0]),
    .s_ready(s_ready[0]), .s_valid(s_valid[0]), .s_data(s_data[0]), .s_done(s_done[0]),
    .s_err(s_err[0]), .busy(busy[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_we(mem_we[0]), .mem_rdata(mem_rdata[0])
  );

  bus_slave_port #(.MEM_DEPTH(2048), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset(rst[1]), .m_valid(m_valid[1]), .m_rw(m_rw[1]), .m_data(m_data[1]),
    .s_ready(s_ready[1]), .s_valid(s_valid[1]), .s_data(s_data[1]), .s_done(s_done[1]),
    .s_err(s_err[1]), .busy(busy[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_we(mem_we[1]), .mem_rdata(mem_rdata[1])
  );

  // RAM models: read data appears 1 cycle (instance 0) or 3 cycles (instance 1) after the address.
  always @(posedge clk) begin
    mem_rdata[0] <= ram_a[mem_addr[0]];
    pipe_b1      <= ram_b[mem_addr[1]];
    pipe_b2      <= pipe_b1;
    mem_rdata[1] <= pipe_b2;
  end

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp_v);
    end
  endtask

  function automatic int exp_size(input int i);
    if (i == 0) return exp_q0.size();
    else return exp_q1.size();
  endfunction

  function automatic rec_t exp_pop(input int i);
    if (i == 0) return exp_q0.pop_front();
    else return exp_q1.pop_front();
  endfunction

  task automatic clear_col(input int i);
    we_cnt[i]  = 0;
    we_t[i]    = -1;
    we_addr[i] = 12'd0;
    we_data[i] = 8'd0;
    tx_cnt[i]  = 0;
    tx_t[i]    = -1;
    tx_byte[i] = 8'd0;
    stray[i]   = 0;
  endtask

  // Push one hand-computed expected completion for instance i.
  task automatic expect_txn(input int i, input int done_t, input int n_we, input logic [11:0] wa,
                            input logic [7:0] wd, input int tx_first, input logic [7:0] rb,
                            input int err);
    rec_t r;
    r.done_t  = done_t;
    r.we_cnt  = n_we;
    r.we_t    = (n_we != 0) ? 20 : -1;
    r.we_addr = wa;
    r.we_data = wd;
    r.tx_cnt  = (tx_first >= 0) ? 8 : 0;
    r.tx_t    = tx_first;
    r.tx_byte = rb;
    r.err     = err;
    if (i == 0) exp_q0.push_back(r);
    else exp_q1.push_back(r);
  endtask

  task automatic drive(input int i, input logic v, input logic rw, input logic d);
    m_valid[i] = v;
    m_rw[i]    = rw;
    m_data[i]  = d;
  endtask

  // Issue a request; abort_at >= 0 drops m_valid on that cycle (T-number).
  task automatic send(input int i, input logic rw, input logic [11:0] addr,
                      input logic [7:0] data, input int abort_at);
    logic [19:0] bits;
    int nbits;
    bits  = {addr, data};
    nbits = rw ? 20 : 12;
    for (int k = 0; k < nbits; k++) begin
      if (k == abort_at) begin
        drive(i, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        return;
      end
      drive(i, 1'b1, rw, bits[19-k]);
      @(posedge clk); #1;
    end
    drive(i, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input int i);
    for (int n = 0; n < 60 && !s_ready[i]; n++) begin
      @(posedge clk); #1;
    end
    check($sformatf("idle_reached%0d", i), int'(s_ready[i]), 1);
  endtask

  // Monitor: samples outputs on the falling edge and scores each completion.
  initial begin
    for (int i = 0; i < 2; i++) begin
      clear_col(i);
      t0[i] = 0;
      busy_cnt[i] = 0;
      rst_pend[i] = 1'b0;
      ready_pend[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (rst_pend[i]) begin
          check($sformatf("reset_outputs_zero%0d", i),
                int'({s_ready[i], s_valid[i], s_data[i], s_done[i], s_err[i], busy[i],
                      mem_we[i], mem_addr[i], mem_wdata[i]}), 0);
        end
        if (ready_pend[i]) begin
          check($sformatf("ready_after_reset%0d", i), int'(s_ready[i]), 1);
        end
        ready_pend[i] = rst_pend[i] && !rst[i];
        rst_pend[i]   = rst[i];
        if (rst[i]) begin
          clear_col(i);
        end else begin
          if (s_ready[i] && m_valid[i]) begin
            t0[i] = cyc;
            busy_cnt[i] = 0;
          end
          if (busy[i]) busy_cnt[i]++;
          if (mem_we[i]) begin
            we_cnt[i]++;
            we_t[i]    = cyc - t0[i];
            we_addr[i] = mem_addr[i];
            we_data[i] = mem_wdata[i];
          end
          if (s_valid[i]) begin
            if (tx_cnt[i] == 0) tx_t[i] = cyc - t0[i];
            tx_byte[i] = {tx_byte[i][6:0], s_data[i]};
            tx_cnt[i]++;
          end else if (s_data[i]) begin
            stray[i]++;
          end
          if (s_err[i] && !s_done[i]) stray[i]++;
          if (s_done[i]) begin
            check($sformatf("done_expected%0d", i), int'(exp_size(i) > 0), 1);
            if (exp_size(i) > 0) begin
              rec_t e;
              e = exp_pop(i);
              check($sformatf("done_time%0d", i), cyc - t0[i], e.done_t);
              check($sformatf("err%0d", i), int'(s_err[i]), e.err);
              check($sformatf("busy_cycles%0d", i), busy_cnt[i], e.done_t);
              check($sformatf("we_count%0d", i), we_cnt[i], e.we_cnt);
              if (e.we_cnt != 0) begin
                check($sformatf("we_time%0d", i), we_t[i], e.we_t);
                check($sformatf("we_addr%0d", i), int'(we_addr[i]), int'(e.we_addr));
                check($sformatf("we_data%0d", i), int'(we_data[i]), int'(e.we_data));
              end
              check($sformatf("tx_count%0d", i), tx_cnt[i], e.tx_cnt);
              if (e.tx_cnt != 0) begin
                check($sformatf("tx_time%0d", i), tx_t[i], e.tx_t);
                check($sformatf("tx_byte%0d", i), int'(tx_byte[i]), int'(e.tx_byte));
              end
              check($sformatf("stray_outputs%0d", i), stray[i], 0);
            end
            clear_col(i);
          end
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "time limit reached");
  end

  // Directed stimulus.
  initial begin
    for (int a = 0; a < 4096; a++) begin
      ram_a[a] = 8'h00;
      ram_b[a] = 8'h00;
    end
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      drive(i, 1'b0, 1'b0, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Write 0x4D to 898: mem_we at T20, s_done at T21.
    expect_txn(0, 21, 1, 12'd898, 8'h4D, -1, 8'h00, 0);
    send(0, 1'b1, 12'd898, 8'h4D, -1);
    wait_idle(0);

    // Read 898 holding 0x55: s_valid T14..T21, s_done T22.
    ram_a[898] = 8'h55;
    expect_txn(0, 22, 0, 12'd0, 8'd0, 14, 8'h55, 0);
    send(0, 1'b0, 12'd898, 8'h00, -1);
    wait_idle(0);

    // Write aborted at T7, then an immediate write of 0xAA to address 5.
    send(0, 1'b1, 12'h123, 8'h99, 7);
    expect_txn(0, 21, 1, 12'd5, 8'hAA, -1, 8'h00, 0);
    send(0, 1'b1, 12'd5, 8'hAA, -1);
    wait_idle(0);

    // Highest in-range address on the default depth.
    expect_txn(0, 21, 1, 12'd4095, 8'h81, -1, 8'h00, 0);
    send(0, 1'b1, 12'd4095, 8'h81, -1);
    wait_idle(0);

    // Reset at T15 of a read: no completion, outputs cleared.
    send(0, 1'b0, 12'd898, 8'h00, -1);
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    wait_idle(0);
    expect_txn(0, 22, 0, 12'd0, 8'd0, 14, 8'h55, 0);
    send(0, 1'b0, 12'd898, 8'h00, -1);
    wait_idle(0);

    // Instance 1: out-of-range write to 3000, no mem_we, s_err with s_done.
    expect_txn(1, 21, 0, 12'd0, 8'd0, -1, 8'h00, 1);
    send(1, 1'b1, 12'd3000, 8'h11, -1);
    wait_idle(1);

    // Out-of-range read of 3000 returns 0x00 despite RAM content.
    ram_b[3000] = 8'hFF;
    expect_txn(1, 24, 0, 12'd0, 8'd0, 16, 8'h00, 1);
    send(1, 1'b0, 12'd3000, 8'h00, -1);
    wait_idle(1);

    // READ_LATENCY=3 read of 898 holding 0x3C: s_done at T24.
    ram_b[898] = 8'h3C;
    expect_txn(1, 24, 0, 12'd0, 8'd0, 16, 8'h3C, 0);
    send(1, 1'b0, 12'd898, 8'h00, -1);
    wait_idle(1);

    // Depth boundary: 2048 is out of range, 2047 is in range.
    expect_txn(1, 21, 0, 12'd0, 8'd0, -1, 8'h00, 1);
    send(1, 1'b1, 12'd2048, 8'h22, -1);
    wait_idle(1);
    ram_b[2047] = 8'hA5;
    expect_txn(1, 24, 0, 12'd0, 8'd0, 16, 8'hA5, 0);
    send(1, 1'b0, 12'd2047, 8'h00, -1);
    wait_idle(1);

    repeat (5) @(posedge clk);
    #1;
    check("pending_completions0", exp_q0.size(), 0);
    check("pending_completions1", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
